// File: rtl/hidden_bp_pkg.sv
// hidden_bp_pkg: shared FSM state encoding and default sizes for the hidden-layer weight updater
package hidden_bp_pkg;
  localparam int N_IN_D = 4;
  localparam int WW_D = 8;
  localparam int HW_D = 10;
  localparam int FW_D = 19;
  localparam int LR_SHIFT_D = 4;
  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_e;
endpackage

// File: rtl/bp_sat_mac.sv
// bp_sat_mac: one weight update w - ((g*h*2) >>> LR_SHIFT), saturated to WW bits, zeroed when gated off
module bp_sat_mac import hidden_bp_pkg::*; #(
  parameter int WW = WW_D,
  parameter int HW = HW_D,
  parameter int FW = FW_D,
  parameter int LR_SHIFT = LR_SHIFT_D
) (
  input  logic signed [FW+1:0] g_i,
  input  logic [HW-1:0]        hidden_i,
  input  logic signed [WW-1:0] w_i,
  input  logic                 gate_i,
  output logic signed [WW-1:0] w_o
);
  // PW holds g*h*2 exactly, so nothing is lost before saturation
  localparam int PW = FW + HW + 4;
  localparam logic signed [PW:0] MAX_V = (PW+1)'((1 << (WW - 1)) - 1);
  localparam logic signed [PW:0] MIN_V = ~MAX_V;
  logic signed [PW-1:0] prod, term;
  logic signed [PW:0] diff;
  always_comb begin
    prod = PW'(g_i) * PW'($signed({1'b0, hidden_i}));
    term = (prod <<< 1) >>> LR_SHIFT;
    diff = (PW+1)'(w_i) - (PW+1)'(term);
    w_o = !gate_i ? '0 : diff > MAX_V ? MAX_V[WW-1:0] : diff < MIN_V ? MIN_V[WW-1:0] : diff[WW-1:0];
  end
endmodule

// File: rtl/hidden_update_engine.sv
// hidden_update_engine: captures operands on start, then updates one weight per cycle through a
// single shared saturating MAC, pulsing done_o after the last weight.
module hidden_update_engine import hidden_bp_pkg::*; #(
  parameter int N_IN = N_IN_D,
  parameter int WW = WW_D,
  parameter int HW = HW_D,
  parameter int FW = FW_D,
  parameter int LR_SHIFT = LR_SHIFT_D
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 clear_i,
  input  logic [N_IN-1:0]      target_i,
  input  logic [FW-1:0]        final_i,
  input  logic [HW-1:0]        hidden_i,
  input  logic [N_IN*WW-1:0]   w_i,
  output logic [N_IN*WW-1:0]   w_o,
  output logic                 busy_o,
  output logic                 done_o
);
  localparam int KW = N_IN > 1 ? $clog2(N_IN) : 1;
  state_e state_q;
  logic [KW-1:0] k_q;
  logic [N_IN-1:0] tgt_q;
  logic [HW-1:0] hid_q;
  logic signed [FW+1:0] g_q;
  logic [N_IN*WW-1:0] w_cap_q, w_q;
  logic busy_q, done_q, last_k;
  logic signed [WW-1:0] w_d;
  assign last_k = k_q == KW'(N_IN - 1);
  bp_sat_mac #(.WW(WW), .HW(HW), .FW(FW), .LR_SHIFT(LR_SHIFT)) u_mac (
    .g_i(g_q),
    .hidden_i(hid_q),
    .w_i(w_cap_q[k_q*WW +: WW]),
    .gate_i(tgt_q[k_q] | (hid_q != '0)),
    .w_o(w_d)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      k_q <= '0;
      tgt_q <= '0;
      hid_q <= '0;
      g_q <= '0;
      w_cap_q <= '0;
      w_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (clear_i) begin
      state_q <= IDLE;
      k_q <= '0;
      w_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          tgt_q <= target_i;
          hid_q <= hidden_i;
          w_cap_q <= w_i;
          g_q <= ((FW+2)'(target_i) - (FW+2)'(final_i)) << 1;
          k_q <= '0;
          busy_q <= 1'b1;
          state_q <= UPDATE;
        end
        UPDATE: begin
          w_q[k_q*WW +: WW] <= w_d;
          k_q <= last_k ? '0 : k_q + 1'b1;
          if (last_k) begin
            state_q <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign w_o = w_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
endmodule

// File: doc/hidden_update_engine.md
HIDDEN_UPDATE_ENGINE -- requirements
Module: hidden_update_engine

Interface
REQ-001 SHALL have parameter N_IN, default 4, number of input weights updated per pass.
REQ-002 SHALL have parameter WW, default 8, signed two's-complement weight width.
REQ-003 SHALL have parameter HW, default 10, unsigned hidden-activation width.
REQ-004 SHALL have parameter FW, default 19, unsigned network-output width.
REQ-005 SHALL have parameter LR_SHIFT, default 4, arithmetic right shift applied to the update term (learning rate 2^-LR_SHIFT).
REQ-006 SHALL have port clk_i  in  1  clock; the block uses one clock.
REQ-007 SHALL have port rst_i  in  1  reset, synchronous and active-low.
REQ-008 SHALL have port start_i  in  1  request one update pass; sampled only in IDLE.
REQ-009 SHALL have port clear_i  in  1  zero all weights and abort any pass.
REQ-010 SHALL have port target_i  in  N_IN  target vector; bit k also gates weight k.
REQ-011 SHALL have port final_i  in  FW  network output.
REQ-012 SHALL have port hidden_i  in  HW  hidden activation.
REQ-013 SHALL have port w_i  in  N_IN*WW  flat current weights; weight k at bits [k*WW +: WW].
REQ-014 SHALL have port w_o  out  N_IN*WW  flat registered updated weights, same packing.
REQ-015 SHALL have port busy_o  out  1  high while a pass is in progress.
REQ-016 SHALL have port done_o  out  1  single-cycle pulse on pass completion.

Function
REQ-017 SHALL implement the FSM states IDLE, UPDATE and DONE.
REQ-018 SHALL, in IDLE with start_i=1, capture target_i, final_i, hidden_i and w_i, clear index k to 0, and go to UPDATE.
REQ-019 SHALL compute gradient g = 2*(zext(target_i) - final_i), signed, FW+2 bits, once at capture.
REQ-020 SHALL, in UPDATE, process exactly one weight k per cycle through k = 0 .. N_IN-1, then go to DONE.
REQ-021 SHALL, when target[k]=1 or hidden != 0, write w_o[k] = sat_WW(w[k] - ((g*hidden*2) >>> LR_SHIFT)), using full-precision signed intermediates and no truncation before saturation.
REQ-022 SHALL, when target[k]=0 and hidden=0, write w_o[k] = 0.
REQ-023 SHALL clamp to +2^(WW-1)-1 or -2^(WW-1) when sat_WW overflows.
REQ-024 SHALL, in DONE, pulse done_o for one cycle and return to IDLE.
REQ-025 SHALL produce its latency as: start accepted at cycle 0, weight k valid on w_o from cycle k+2, done_o high at cycle N_IN+1.
REQ-026 SHALL drive busy_o=1 in UPDATE and DONE and 0 in IDLE.
REQ-027 SHALL ignore start_i while busy_o=1.
REQ-028 SHALL hold w_o for weights not yet processed in a pass at their previous value.
REQ-029 SHALL, on clear_i=1 in any state, zero all of w_o next cycle, go to IDLE with done_o=0, and give clear_i priority over start_i.
REQ-030 SHALL NOT alter the captured operands when inputs change mid-pass.

Reset
REQ-031 SHALL, when rst_i=0 at a clk_i edge, reset w_o to all zeros, busy_o to 0, done_o to 0, state to IDLE and k to 0.
REQ-032 SHALL abort a pass on reset mid-pass without producing a done_o pulse.
REQ-033 SHALL give reset priority over clear_i and start_i.

Structure
REQ-034 SHALL take the FSM state enum and the default parameter values from shared package hidden_bp_pkg.
REQ-035 SHALL place the multiply-subtract-shift-saturate datapath for one weight in sub-module bp_sat_mac, instantiated once and time-shared across k.

Verification
REQ-036 SHALL check this update: target=4'b0001, final=0, hidden=8, w=10 each -> g=2, term=32>>>4=2; all four weights = 8; done_o at cycle 5.
REQ-037 SHALL check saturation: target=0, final=1000, hidden=100, w0=10 -> term=-25000; w_o[0]=127. With target=15, final=0, hidden=1023, w=-100 -> -128.
REQ-038 SHALL check gating: hidden=0, target=4'b0101, w={40,30,20,10} -> w_o={0,30,0,10}.
REQ-039 SHALL check clear mid-pass: clear_i at cycle 2 -> w_o all 0 next cycle, busy_o=0, no done_o.
REQ-040 SHALL check start while busy: second start_i at cycle 1 is ignored, with exactly one done_o.
REQ-041 SHALL check reset mid-pass: rst_i=0 at cycle 3 -> outputs zero, IDLE; a new start afterwards completes normally.
